lfsr_test_ctrl: RTL and testbench

LFSR_TEST_CTRL -- requirements
Module: lfsr_test_ctrl

---
 rtl/lfsr_test_ctrl.sv | 156 +++++++++++++++
 tb/tb_lfsr_test_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_test_ctrl.sv
// lfsr_test_ctrl: sequences one LFSR self-test run.
// A run loads the seed, clears the counters and discards the first partial
// period. It then captures the ones/zeros totals at the end of the first full
// period and compares them against the expected values.
// A 16-bit watchdog ends a run whose LFSR never reports end-of-period.
module lfsr_test_ctrl #(
  parameter int unsigned    W         = 13,
  parameter logic [W-1:0]   EXP_ONES  = 13'd4095,
  parameter logic [W-1:0]   EXP_ZEROS = 13'd4095,
  parameter logic [15:0]    TMO       = 16'd16400
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          max_tick,
  input  logic [W-1:0]  ones_count,
  input  logic [W-1:0]  zeros_count,
  output logic          lfsr_load,
  output logic          lfsr_en,
  output logic          cnt_clr,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [W-1:0]  cap_ones,
  output logic [W-1:0]  cap_zeros,
  output logic [7:0]    pass_runs
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SKIP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  state_t       state_r;
  logic [15:0]  wdog_r;
  logic [15:0]  wdog_inc_s;
  logic         wdog_hit_s;
  logic         pass_cmp_s;

  // The watchdog limit is reached on the cycle whose increment lands on TMO.
  assign wdog_inc_s = wdog_r + 16'd1;
  assign wdog_hit_s = (wdog_inc_s >= TMO);
  // Comparing the live counts gives the same verdict as comparing the captures.
  assign pass_cmp_s = (ones_count == EXP_ONES) && (zeros_count == EXP_ZEROS);

  // Sequencer: state, watchdog and every registered output in one block so
  // that done/pass become visible in the CHECK cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      wdog_r    <= 16'd0;
      lfsr_load <= 1'b0;
      lfsr_en   <= 1'b0;
      cnt_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      cap_ones  <= '0;
      cap_zeros <= '0;
      pass_runs <= 8'd0;
    end else begin
      // Pulse outputs default low; the branches below raise them for one cycle.
      lfsr_load <= 1'b0;
      cnt_clr   <= 1'b0;
      done      <= 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
        // Abort drops the run silently: results of the run stay as they are.
        state_r <= ST_IDLE;
        lfsr_en <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && !abort) begin
              state_r   <= ST_LOAD;
              lfsr_load <= 1'b1;
              cnt_clr   <= 1'b1;
              busy      <= 1'b1;
              pass      <= 1'b0;
              timeout   <= 1'b0;
              cap_ones  <= '0;
              cap_zeros <= '0;
              wdog_r    <= 16'd0;
            end else begin
              busy    <= 1'b0;
              lfsr_en <= 1'b0;
            end
          end
          ST_LOAD: begin
            state_r <= ST_SKIP;
            lfsr_en <= 1'b1;
            wdog_r  <= 16'd0;
          end
          ST_SKIP: begin
            wdog_r <= wdog_inc_s;
            if (max_tick) begin
              // End of the partial period: the full period starts now.
              state_r <= ST_RUN;
            end else if (wdog_hit_s) begin
              state_r <= ST_CHECK;
              lfsr_en <= 1'b0;
              timeout <= 1'b1;
              pass    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= ST_SKIP;
            end
          end
          ST_RUN: begin
            wdog_r <= wdog_inc_s;
            if (max_tick) begin
              // A tick on the watchdog-limit cycle still counts as a capture.
              state_r   <= ST_CHECK;
              lfsr_en   <= 1'b0;
              cap_ones  <= ones_count;
              cap_zeros <= zeros_count;
              pass      <= pass_cmp_s;
              done      <= 1'b1;
              if (pass_cmp_s && (pass_runs != 8'd255)) begin
                pass_runs <= pass_runs + 8'd1;
              end else begin
                pass_runs <= pass_runs;
              end
            end else if (wdog_hit_s) begin
              state_r <= ST_CHECK;
              lfsr_en <= 1'b0;
              timeout <= 1'b1;
              pass    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
          ST_CHECK: begin
            // Result is presented for this one cycle; always pass through IDLE.
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            lfsr_en <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            lfsr_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_test_ctrl.sv
// Bench for lfsr_test_ctrl: a driver issues whole test runs and pushes the
// expected run outcome into a queue; a monitor pops it on every done pulse.
module tb_lfsr_test_ctrl;

  localparam int          TMO_I = 16400;
  localparam logic [12:0] EXP_V = 13'd4095;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        max_tick = 1'b0;
  logic [12:0] ones_count = 13'd0;
  logic [12:0] zeros_count = 13'd0;
  logic        lfsr_load, lfsr_en, cnt_clr, busy, done, pass, timeout;
  logic [12:0] cap_ones, cap_zeros;
  logic [7:0]  pass_runs;

  typedef struct {
    logic        pass;
    logic        to;
    logic [12:0] co;
    logic [12:0] cz;
    logic [7:0]  pr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   dones_seen = 0;
  int   dones_exp = 0;

  // Outcome of the most recent run as the model sees it.
  logic        m_pass = 1'b0;
  logic        m_to = 1'b0;
  logic [12:0] m_co = 13'd0;
  logic [12:0] m_cz = 13'd0;
  int          m_pr = 0;

  lfsr_test_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .max_tick(max_tick),
    .ones_count(ones_count), .zeros_count(zeros_count),
    .lfsr_load(lfsr_load), .lfsr_en(lfsr_en), .cnt_clr(cnt_clr), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .cap_ones(cap_ones),
    .cap_zeros(cap_zeros), .pass_runs(pass_runs)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding run outcome.
  always @(negedge clk) begin
    if (!rst && done) begin
      dones_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_pass", {31'd0, pass}, {31'd0, e.pass});
        chk("mon_timeout", {31'd0, timeout}, {31'd0, e.to});
        chk("mon_cap_ones", {19'd0, cap_ones}, {19'd0, e.co});
        chk("mon_cap_zeros", {19'd0, cap_zeros}, {19'd0, e.cz});
        chk("mon_pass_runs", {24'd0, pass_runs}, {24'd0, e.pr});
        chk("mon_en_low", {31'd0, lfsr_en}, 32'd0);
        chk("mon_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  // One test run: SKIP tick after skip_len quiet cycles, RUN tick after
  // run_len more; never=1 suppresses both ticks; abort_idx>0 aborts on that
  // SKIP/RUN cycle; hold keeps start high after the run is launched.
  task automatic do_run(input int skip_len, input int run_len, input bit never,
                        input logic [12:0] o, input logic [12:0] z,
                        input int abort_idx, input bit hold);
    int skip_idx, final_idx, limit;
    bit to_exp, ab;
    exp_t e;
    skip_idx  = skip_len + 1;
    final_idx = never ? 32'h7fff_ffff : skip_idx + run_len + 1;
    to_exp    = (final_idx > TMO_I);
    limit     = to_exp ? TMO_I : final_idx;
    ab        = (abort_idx > 0) && (abort_idx <= limit);
    if (ab) limit = abort_idx;
    m_pass = 1'b0; m_to = 1'b0; m_co = 13'd0; m_cz = 13'd0;
    if (!ab) begin
      if (to_exp) begin
        m_to = 1'b1;
      end else begin
        m_co = o; m_cz = z;
        m_pass = (o == EXP_V) && (z == EXP_V);
        if (m_pass) m_pr = (m_pr >= 255) ? 255 : m_pr + 1;
      end
      e.pass = m_pass; e.to = m_to; e.co = m_co; e.cz = m_cz; e.pr = m_pr[7:0];
      exp_q.push_back(e);
      dones_exp++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk("load_pulse", {31'd0, lfsr_load}, 32'd1);
    chk("clr_pulse", {31'd0, cnt_clr}, 32'd1);
    chk("load_en_low", {31'd0, lfsr_en}, 32'd0);
    @(posedge clk); #1;
    chk("skip_en", {31'd0, lfsr_en}, 32'd1);
    chk("load_once", {31'd0, lfsr_load}, 32'd0);
    for (int i = 1; i <= limit; i++) begin
      max_tick = !never && ((i == skip_idx) || (i == final_idx));
      abort    = ab && (i == abort_idx);
      if (i == final_idx) begin
        ones_count = o; zeros_count = z;
      end else begin
        ones_count = 13'($urandom); zeros_count = 13'($urandom);
      end
      @(posedge clk); #1;
    end
    max_tick = 1'b0; abort = 1'b0;
    if (ab) begin
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_en", {31'd0, lfsr_en}, 32'd0);
      chk("abort_nodone", {31'd0, done}, 32'd0);
      chk("abort_pass", {31'd0, pass}, {31'd0, m_pass});
    end else begin
      chk("check_en", {31'd0, lfsr_en}, 32'd0);
      @(posedge clk); #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("done_once", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [12:0] ro, rz;
    // Reset state.
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_en", {31'd0, lfsr_en}, 32'd0);
    chk("rst_pr", {24'd0, pass_runs}, 32'd0);
    chk("rst_cap", {19'd0, cap_ones}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal passing run: ticks on SKIP/RUN cycles 5 and 8196.
    do_run(4, 8190, 1'b0, 13'd4095, 13'd4095, 0, 1'b0);
    // Same sequence with wrong counts.
    do_run(4, 8190, 1'b0, 13'd4096, 13'd4094, 0, 1'b0);

    // Randomised short runs, start held high on some of them.
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        ro = EXP_V; rz = EXP_V;
      end else begin
        ro = 13'($urandom); rz = ($urandom_range(1, 0) == 1) ? EXP_V : 13'($urandom);
      end
      do_run($urandom_range(6, 0), $urandom_range(20, 0), 1'b0, ro, rz, 0, (k % 5) == 2);
    end

    // Abort during RUN.
    do_run(2, 30, 1'b0, EXP_V, EXP_V, 10, 1'b0);
    // Abort and start together in IDLE.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);
    chk("idle_abort_load", {31'd0, lfsr_load}, 32'd0);
    start = 1'b0; abort = 1'b0;

    // Watchdog: no tick ever.
    do_run(0, 0, 1'b1, EXP_V, EXP_V, 0, 1'b0);
    // Tick on the very cycle the watchdog limit is reached.
    do_run(0, TMO_I - 2, 1'b0, EXP_V, EXP_V, 0, 1'b0);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    max_tick = 1'b1;
    @(posedge clk); #1;
    max_tick = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_en", {31'd0, lfsr_en}, 32'd0);
    chk("arst_pass", {31'd0, pass}, 32'd0);
    chk("arst_pr", {24'd0, pass_runs}, 32'd0);
    chk("arst_cap", {19'd0, cap_zeros}, 32'd0);
    m_pass = 1'b0; m_to = 1'b0; m_co = 13'd0; m_cz = 13'd0; m_pr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Saturation of the passing-run counter.
    for (int k = 0; k < 256; k++) begin
      do_run(0, $urandom_range(2, 0), 1'b0, EXP_V, EXP_V, 0, 1'b0);
    end
    chk("sat_pass_runs", {24'd0, pass_runs}, 32'd255);

    chk("dones_count", dones_seen, dones_exp);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
